// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one multicycle bitwise logic unit (NOT/AND/OR/XOR).
// Optional ARB_LOCK_EN adds a lock port that lets the owner chain operations without re-arbitration.
module alu_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
`ifdef ARB_LOCK_EN
    input  logic [NREQ-1:0]   lock,
`endif
    input  logic [2*NREQ-1:0] op_bus,
    input  logic [W*NREQ-1:0] a_bus,
    input  logic [W*NREQ-1:0] b_bus,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [W-1:0]      res,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } req_t;

    // Packed-array views share the flat bus layout, so a plain assign unpacks them.
    logic [NREQ-1:0][1:0]   op_arr;
    logic [NREQ-1:0][W-1:0] a_arr;
    logic [NREQ-1:0][W-1:0] b_arr;

    assign op_arr = op_bus;
    assign a_arr  = a_bus;
    assign b_arr  = b_bus;

    state_t         state;
    req_t           cur;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  owner;
    logic [PW-1:0]  win;
    logic [CW-1:0]  cnt;

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
        logic [NREQ-1:0] one;
        one = {{(NREQ-1){1'b0}}, 1'b1};
        return one << i;
    endfunction

    function automatic logic [W-1:0] alu(input req_t r);
        case (r.op)
            2'b00:   return ~r.a;
            2'b01:   return r.a & r.b;
            2'b10:   return r.a | r.b;
            default: return r.a ^ r.b;
        endcase
    endfunction

    // Search starts just past the last served requester, so it ends up lowest priority.
    always_comb begin
        int   idx;
        logic found;
        win   = ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                win   = PW'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            done  <= '0;
            res   <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
            owner <= '0;
            ptr   <= PW'(NREQ - 1);
            cur   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (|req) begin
                        cur   <= '{op: op_arr[win], a: a_arr[win], b: b_arr[win]};
                        owner <= win;
                        gnt   <= onehot(win);
                        cnt   <= CW'(LAT - 1);
                        state <= EXEC;
                        busy  <= 1'b1;
                    end else begin
                        gnt  <= '0;
                        busy <= 1'b0;
                    end
                end
                EXEC: begin
                    gnt  <= '0;
                    busy <= 1'b1;
                    if (cnt == '0) begin
                        res   <= alu(cur);
                        done  <= onehot(owner);
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    done <= '0;
`ifdef ARB_LOCK_EN
                    if (lock[owner] && req[owner]) begin
                        cur   <= '{op: op_arr[owner], a: a_arr[owner], b: b_arr[owner]};
                        gnt   <= onehot(owner);
                        cnt   <= CW'(LAT - 1);
                        state <= EXEC;
                        busy  <= 1'b1;
                    end else begin
                        gnt   <= '0;
                        ptr   <= owner;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
`else
                    gnt   <= '0;
                    ptr   <= owner;
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end
                default: begin
                    gnt   <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter (NREQ=4, W=8, LAT=2).
module tb_alu_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int LAT  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
`ifdef ARB_LOCK_EN
    logic [NREQ-1:0]   lock;
`endif
    logic [2*NREQ-1:0] op_bus;
    logic [W*NREQ-1:0] a_bus;
    logic [W*NREQ-1:0] b_bus;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [W-1:0]      res;
    logic              busy;

    int n_chk  = 0;
    int n_fail = 0;

    alu_share_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
`ifdef ARB_LOCK_EN
        .lock   (lock),
`endif
        .op_bus (op_bus),
        .a_bus  (a_bus),
        .b_bus  (b_bus),
        .gnt    (gnt),
        .done   (done),
        .res    (res),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rq(input int i, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        op_bus[2*i +: 2] = op;
        a_bus[W*i +: W]  = a;
        b_bus[W*i +: W]  = b;
    endtask

    // Grant and completion must never be multi-hot.
    always @(negedge clk) begin
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("done_onehot0", 32'($onehot0(done)), 32'd1);
    end

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        rst    = 1'b1;
        req    = '0;
`ifdef ARB_LOCK_EN
        lock   = '0;
`endif
        op_bus = '0;
        a_bus  = '0;
        b_bus  = '0;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res", 32'(res), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // single NOT from requester 0
        set_rq(0, 2'b00, 8'h5A, 8'h00);
        req = 4'b0001;
        tick();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_busy1", 32'(busy), 32'd1);
        req = '0;
        tick();
        chk("t1_gnt_clr", 32'(gnt), 32'h0);
        chk("t1_done_early", 32'(done), 32'h0);
        chk("t1_busy2", 32'(busy), 32'd1);
        tick();
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_res", 32'(res), 32'hA5);
        chk("t1_busy3", 32'(busy), 32'd1);
        tick();
        chk("t1_done_clr", 32'(done), 32'h0);
        chk("t1_busy_idle", 32'(busy), 32'd0);
        chk("t1_res_hold", 32'(res), 32'hA5);

        // round robin with all four requesting AND
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < NREQ; i++) set_rq(i, 2'b01, 8'hF0, 8'h3C);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_gnt", 32'(gnt), 32'(1) << order[k]);
            tick();
            chk("rr_gnt_clr", 32'(gnt), 32'h0);
            tick();
            chk("rr_done", 32'(done), 32'(1) << order[k]);
            chk("rr_res", 32'(res), 32'h30);
            if (k == 4) req = '0;
            tick();
            chk("rr_idle", 32'(busy), 32'd0);
        end

        // requester 2 XOR; operand change after grant must not matter
        set_rq(2, 2'b11, 8'hFF, 8'h0F);
        req = 4'b0100;
        tick();
        chk("cap_gnt", 32'(gnt), 32'h4);
        set_rq(2, 2'b11, 8'h00, 8'h0F);
        req = '0;
        tick();
        tick();
        chk("cap_done", 32'(done), 32'h4);
        chk("cap_res", 32'(res), 32'hF0);
        tick();

        // reset during EXEC of requester 1
        req = 4'b0010;
        tick();
        chk("ra_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick();
        rst = 1'b1;
        tick();
        chk("ra_gnt0", 32'(gnt), 32'h0);
        chk("ra_done0", 32'(done), 32'h0);
        chk("ra_busy0", 32'(busy), 32'd0);
        chk("ra_res0", 32'(res), 32'h0);
        rst = 1'b0;
        tick();
        chk("ra_no_done", 32'(done), 32'h0);
        req = 4'b1010;
        tick();
        chk("ra_first_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick();
        tick();
        chk("ra_done", 32'(done), 32'h2);
        chk("ra_res", 32'(res), 32'h30);
        tick();

        // requests arriving while busy wait for IDLE
        set_rq(0, 2'b10, 8'hF0, 8'h3C);
        req = 4'b0001;
        tick();
        chk("bz_gnt0", 32'(gnt), 32'h1);
        req = 4'b0110;
        tick();
        chk("bz_exec_gnt", 32'(gnt), 32'h0);
        tick();
        chk("bz_done0", 32'(done), 32'h1);
        chk("bz_res0", 32'(res), 32'hFC);
        chk("bz_done_gnt", 32'(gnt), 32'h0);
        tick();
        chk("bz_ret_gnt", 32'(gnt), 32'h0);
        tick();
        chk("bz_gnt1", 32'(gnt), 32'h2);
        req = 4'b0100;
        tick();
        tick();
        chk("bz_done1", 32'(done), 32'h2);
        tick();
        tick();
        chk("bz_gnt2", 32'(gnt), 32'h4);
        req = '0;
        tick();
        tick();
        chk("bz_done2", 32'(done), 32'h4);
        tick();
        chk("bz_idle", 32'(busy), 32'd0);

`ifdef ARB_LOCK_EN
        // locked owner chains back-to-back operations
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        set_rq(0, 2'b10, 8'h01, 8'h02);
        lock = 4'b0001;
        req  = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("lk_gnt", 32'(gnt), 32'h1);
            chk("lk_busy", 32'(busy), 32'd1);
            if (k == 2) lock = '0;
            tick();
            tick();
            chk("lk_done", 32'(done), 32'h1);
            chk("lk_res", 32'(res), 32'h03);
        end
        tick();
        chk("lk_release_gnt", 32'(gnt), 32'h0);
        chk("lk_release_busy", 32'(busy), 32'd0);
        tick();
        chk("lk_next_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick();
        tick();
        chk("lk_next_done", 32'(done), 32'h2);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one multicycle logic unit (NOT/AND/OR/XOR) among NREQ requesters.
- Each requester presents an opcode and operands. The arbiter grants one requester, captures its operands, runs the unit for LAT cycles, then returns the result with a one-hot done pulse.
- Sits between the processor's functional blocks and the shared logic unit; it is the only path to that unit.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 8, operand/result width in bits
- LAT, 2, execute cycles of the shared unit (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request level
- op_bus  in  2*NREQ  opcode of requester i at [2i+1:2i]; 00 NOT a, 01 AND, 10 OR, 11 XOR
- a_bus  in  W*NREQ  operand a of requester i at [W*i+W-1:W*i]
- b_bus  in  W*NREQ  operand b, same packing; ignored for NOT
- gnt  out  NREQ  one-hot grant, one-cycle pulse
- done  out  NREQ  one-hot completion, one-cycle pulse
- res  out  W  result; valid while done is high, held until the next done
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset, checked before all else: state=IDLE, gnt=0, done=0, res=0, busy=0, cnt=0, owner=0, ptr=NREQ-1, so requester 0 wins first. A reset mid-operation aborts with no done and no result update.
- FSM states: IDLE, EXEC, DONE. All outputs are registered.
- IDLE:
  - If |req at an edge, the winner is the first set bit searching ptr+1, ptr+2, ... modulo NREQ.
  - At that edge: capture the winner's op/a/b, set owner=winner, gnt=onehot(winner), cnt=LAT-1, state=EXEC.
  - If no req, remain in IDLE.
- EXEC:
  - gnt clears after its first cycle.
  - If cnt==0: res = f(op,a,b) on the captured operands, done=onehot(owner), state=DONE. Otherwise cnt decrements.
- DONE: done clears, ptr=owner, state=IDLE.
- Latency: req sampled in IDLE at cycle 0 gives gnt in cycle 1 and done/res in cycle LAT+1. busy is high in cycles 1..LAT+1. IDLE resumes in cycle LAT+2.
- Requester rules:
  - Hold req, op and operands stable until gnt is seen.
  - Operands are captured at the edge that asserts gnt, so changes after that edge have no effect.
  - A req still high when the FSM returns to IDLE is treated as a new request.
- req changes during EXEC/DONE are ignored. Arbitration occurs only in IDLE, except as described under Optional Feature.
- Simultaneous requests: exactly one grant. The just-served requester gets lowest priority next round.
- Arithmetic: purely bitwise, W bits; NOT result = ~a.
- Illegal one-hot is impossible by construction; the bench asserts $onehot0(gnt) and $onehot0(done) every cycle.

Optional Feature:
- Macro: ARB_LOCK_EN.
- When defined:
  - Adds input port lock (NREQ bits), placed after req.
  - In DONE, if lock[owner] and req[owner] are both high: recapture that owner's op/a/b, pulse gnt=onehot(owner), set cnt=LAT-1, go directly to EXEC.
  - ptr is not updated, so back-to-back ops by the same owner skip IDLE: next done arrives LAT+1 cycles after the previous one.
  - Starvation avoidance is the locking requester's responsibility.
- When undefined: no lock port; DONE always returns to IDLE.

Test Plan:
- Reset, then req=0001, op0=00, a0=8'h5A, LAT=2 → gnt=0001 in cycle 1; done=0001 and res=8'hA5 in cycle 3; busy high cycles 1–3.
- req=1111 held continuously, all op=01 (AND), a_i=8'hF0, b_i=8'h3C → grant order 0,1,2,3,0; each done carries res=8'h30; a new grant every LAT+2=4 cycles.
- Requester 2: op=11, a=8'hFF, b=8'h0F; a changed to 8'h00 the cycle after gnt → res=8'hF0 (captured value used).
- Assert rst during EXEC of requester 1 → next cycle gnt=done=busy=0, res unchanged from reset value 0; first post-reset request from 1 and 3 together grants requester 1.
- req=0110 arriving while busy serving requester 0 → no gnt until IDLE; then requester 1 granted first, requester 2 next.
- ARB_LOCK_EN defined: lock=0001, req=0011 held, requester 0 op=10, a=8'h01, b=8'h02 → three consecutive dones to requester 0 each 3 cycles apart with res=8'h03; dropping lock[0] → requester 1 granted next.
